// File: rtl/delay_pkg.sv
// delay_pkg: shared constants, channel state encoding and the effective
// latency helper for multi_delay_counter.
package delay_pkg;

  localparam int          LFSR_W    = 16;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {DLY_IDLE, DLY_RUN} dly_state_e;

  // Effective latency L. Arguments are zero-extended to 16 bits by the caller
  // and the 17-bit result is truncated to CNT_WIDTH+1 bits there.
  // Fixed mode: max(bound, 1). Random mode: (rnd & bound) + 1.
  function automatic logic [16:0] dly_eff_len(input logic [15:0] bound,
                                              input logic [15:0] rnd,
                                              input logic        rand_mode);
    if (rand_mode)        return {1'b0, rnd & bound} + 17'd1;
    else if (bound == '0) return 17'd1;
    else                  return {1'b0, bound};
  endfunction

endpackage

// File: rtl/delay_channel.sv
// delay_channel: one latency channel. Accepts a start pulse, latches the
// effective latency L and raises o_done exactly L cycles after the start.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : 1-cycle start request
//   i_bound        : latency bound (sampled with i_start)
//   i_rnd          : pseudo-random value for this channel (sampled with i_start)
//   i_rand         : random-latency mode select (sampled with i_start)
//   i_cancel       : abort; highest priority, masks o_done
//   o_busy         : channel is counting
//   o_done         : 1-cycle completion pulse
module delay_channel
  import delay_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_bound,
  input  logic [CNT_WIDTH-1:0] i_rnd,
  input  logic                 i_rand,
  input  logic                 i_cancel,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int LW = CNT_WIDTH + 1;  // holds L up to 2^CNT_WIDTH

  dly_state_e    r_state, w_state_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic [LW-1:0] w_len_new;
  logic          w_done_raw;
  logic          w_accept;

  assign w_len_new  = LW'(dly_eff_len(16'(i_bound), 16'(i_rnd), i_rand));
  assign w_done_raw = (r_state == DLY_RUN) && (r_cnt == r_len - LW'(1));
  // Restart is allowed on the done cycle so back-to-back runs keep o_busy high.
  assign w_accept   = i_start && !i_cancel && ((r_state == DLY_IDLE) || w_done_raw);

  assign o_busy = (r_state == DLY_RUN);
  assign o_done = w_done_raw && !i_cancel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DLY_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    if (i_cancel) begin
      w_state_nxt = DLY_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_state_nxt = DLY_RUN;
      w_cnt_nxt   = '0;
      w_len_nxt   = w_len_new;
    end else if (w_done_raw) begin
      w_state_nxt = DLY_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == DLY_RUN) begin
      w_cnt_nxt   = r_cnt + LW'(1);
    end
  end

endmodule

// File: rtl/multi_delay_counter.sv
// multi_delay_counter: CHANNELS independent latency generators sharing one
// free-running 16-bit Galois LFSR used for random-latency mode.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : per-channel 1-cycle start pulse
//   i_bound        : per-channel bound, channel c in [c*CNT_WIDTH +: CNT_WIDTH]
//   i_rand         : per-channel random-latency mode select
//   i_cancel       : per-channel abort
//   o_busy         : per-channel counting flag
//   o_done         : per-channel 1-cycle completion pulse
module multi_delay_counter
  import delay_pkg::*;
#(
  parameter int          CHANNELS  = 2,
  parameter int          CNT_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [CHANNELS-1:0]           i_start,
  input  logic [CHANNELS*CNT_WIDTH-1:0] i_bound,
  input  logic [CHANNELS-1:0]           i_rand,
  input  logic [CHANNELS-1:0]           i_cancel,
  output logic [CHANNELS-1:0]           o_busy,
  output logic [CHANNELS-1:0]           o_done
);

  logic [LFSR_W-1:0]                   r_lfsr;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]  w_rnd;

  // Advances every cycle regardless of channel activity.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Channel c sees the LFSR rotated right by c so channels draw different values.
    for (genvar b = 0; b < CNT_WIDTH; b++) begin : g_rot
      assign w_rnd[c][b] = r_lfsr[(b + c) % LFSR_W];
    end

    delay_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (i_start[c]),
      .i_bound  (i_bound[c*CNT_WIDTH +: CNT_WIDTH]),
      .i_rnd    (w_rnd[c]),
      .i_rand   (i_rand[c]),
      .i_cancel (i_cancel[c]),
      .o_busy   (o_busy[c]),
      .o_done   (o_done[c])
    );
  end

endmodule

// File: tb/tb_multi_delay_counter.sv
module tb_multi_delay_counter;

  localparam int          CH   = 2;
  localparam int          CW   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    i_start = '0, i_cancel = '0, rmode = '0;
  logic [CW-1:0]    bnd [CH];
  logic [CH*CW-1:0] i_bound;
  logic [CH-1:0]    o_busy, o_done;

  assign i_bound = {bnd[1], bnd[0]};

  multi_delay_counter #(.CHANNELS(CH), .CNT_WIDTH(CW), .LFSR_SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_bound(i_bound),
    .i_rand(rmode), .i_cancel(i_cancel), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct { int start; int done; } exp_t;

  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  exp_t q [CH][$];
  int   b_lo [CH], b_hi [CH];
  logic [15:0] m_lfsr;
  bit   rec = 0;
  int   lat_log [$];
  int   hist [17];
  int   seq_a [$], seq_b [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: Galois, x^16+x^14+x^13+x^11+1.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Monitor: busy window and done scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("busy%0d", c), int'(o_busy[c]), int'(cyc >= b_lo[c] && cyc <= b_hi[c]));
      if (o_done[c]) begin
        if (q[c].size() == 0) chk($sformatf("done%0d_unexpected", c), 1, 0);
        else begin
          e = q[c].pop_front();
          chk($sformatf("done%0d_cycle", c), cyc, e.done);
          lat = cyc - e.start;
          if (rec && c == 0) begin
            lat_log.push_back(lat);
            chk("rand_lat_range", int'(lat >= 1 && lat <= 16), 1);
            if (lat >= 1 && lat <= 16) hist[lat]++;
          end
        end
      end else if (q[c].size() != 0 && q[c][0].done <= cyc) begin
        chk($sformatf("done%0d_missing", c), 0, 1);
        void'(q[c].pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int exp_len(input int c);
    logic [15:0] rot;
    logic [CW-1:0] rnd;
    rot = (m_lfsr >> c) | (m_lfsr << (16 - c));
    rnd = rot[CW-1:0];
    if (rmode[c]) return int'(rnd & bnd[c]) + 1;
    return (bnd[c] == 0) ? 1 : int'(bnd[c]);
  endfunction

  // Drive one cycle of start/cancel and push the expected outcome.
  task automatic drive(input logic [CH-1:0] st, input logic [CH-1:0] cn);
    for (int c = 0; c < CH; c++) begin
      bit busy_now, done_now, acc;
      int L;
      busy_now = (cyc >= b_lo[c] && cyc <= b_hi[c]);
      done_now = (q[c].size() != 0) && (q[c][0].done == cyc);
      acc = st[c] && !cn[c] && (!busy_now || done_now);
      L = exp_len(c);
      if (cn[c]) begin
        q[c].delete();
        if (b_hi[c] > cyc) b_hi[c] = cyc;
      end
      if (acc) begin
        if (!busy_now) b_lo[c] = cyc + 1;
        b_hi[c] = cyc + L;
        q[c].push_back('{start: cyc, done: cyc + L});
      end
    end
    i_start = st; i_cancel = cn;
    tick();
    i_start = '0; i_cancel = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < CH; c++) begin q[c].delete(); b_lo[c] = 1; b_hi[c] = 0; end
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((cyc <= b_hi[0] || cyc <= b_hi[1]) && guard < 1000) begin tick(); guard++; end
    chk("idle_timeout", int'(guard >= 1000), 0);
    tick();
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      while (cyc < b_hi[0]) tick();
      drive(2'b01, 2'b00);
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bnd[0] = '0; bnd[1] = '0;
    for (int c = 0; c < CH; c++) begin b_lo[c] = 1; b_hi[c] = 0; end
    do_reset();

    // Fixed bound 5 on CH0, start at cycle 10.
    while (cyc < 10) tick();
    bnd[0] = 8'd5;
    drive(2'b01, 2'b00);
    wait_idle();

    // CH1 bound 0 and 1: both L=1.
    bnd[1] = 8'd0; drive(2'b10, 2'b00); wait_idle();
    bnd[1] = 8'd1; drive(2'b10, 2'b00); wait_idle();

    // CH0 bound 3, back-to-back restarts, with an ignored mid-run start.
    bnd[0] = 8'd3;
    drive(2'b01, 2'b00);
    tick();
    drive(2'b01, 2'b00);           // cycle 2 of the run: ignored
    for (int i = 0; i < 3; i++) begin
      while (cyc < b_hi[0]) tick();
      drive(2'b01, 2'b00);         // on the done cycle: restart
    end
    wait_idle();

    // CH1 bound 8, cancel at cycle 4; then cancel+start together.
    bnd[1] = 8'd8;
    drive(2'b10, 2'b00);
    repeat (3) tick();
    drive(2'b00, 2'b10);
    wait_idle();
    drive(2'b10, 2'b10);
    repeat (12) tick();

    // Both channels simultaneously, different bounds.
    bnd[0] = 8'd4; bnd[1] = 8'd7;
    drive(2'b11, 2'b00);
    wait_idle();

    // Random mode, 1000 starts.
    for (int v = 0; v < 17; v++) hist[v] = 0;
    bnd[0] = 8'h0F; rmode[0] = 1'b1;
    rec = 1;
    rand_run(1000);
    rec = 0;
    for (int v = 1; v <= 16; v++) chk($sformatf("rand_hit_%0d", v), int'(hist[v] > 0), 1);

    // Same seed after reset reproduces the latency sequence.
    do_reset(); lat_log.delete(); rec = 1; rand_run(20); rec = 0; seq_a = lat_log;
    do_reset(); lat_log.delete(); rec = 1; rand_run(20); rec = 0; seq_b = lat_log;
    chk("repro_len", seq_b.size(), 20);
    for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
      chk($sformatf("repro_%0d", i), seq_b[i], seq_a[i]);
    rmode[0] = 1'b0;

    // Reset mid-run on both channels; no stray done afterwards.
    bnd[0] = 8'd20; bnd[1] = 8'd20;
    drive(2'b11, 2'b00);
    repeat (4) tick();
    do_reset();
    repeat (30) tick();

    // Bound/mode change during a run does not affect the latency.
    bnd[0] = 8'd6;
    drive(2'b01, 2'b00);
    bnd[0] = 8'd2; rmode[0] = 1'b1;
    wait_idle();
    rmode[0] = 1'b0;

    chk("sb_empty", q[0].size() + q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
